// File: rtl/subset_coord_gen.sv
// Streaming subset coordinate generator: latches a centre and half-size, then emits
// size*size FP32 (x,y) points over valid/ready using one shared 5-stage FP32 adder.

module subset_fp32_add (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        sub,
   output logic        done,
   output logic [31:0] result
);
   logic [4:0]  vld;
   logic        b_sign, a_big;
   logic [7:0]  diff;
   logic [26:0] a_m, b_m;
   logic [4:0]  lz;

   logic        s1_sign, s1_eff_sub, s1_byp;
   logic [7:0]  s1_exp;
   logic [26:0] s1_big, s1_small;
   logic [31:0] s1_byp_val;
   logic        s2_sign, s2_byp;
   logic [7:0]  s2_exp;
   logic [27:0] s2_sum;
   logic [31:0] s2_byp_val;
   logic        s3_sign, s3_byp, s3_zero;
   logic [7:0]  s3_exp;
   logic [26:0] s3_m;
   logic [31:0] s3_byp_val;
   logic        s4_sign, s4_byp, s4_zero;
   logic [7:0]  s4_exp;
   logic [22:0] s4_man;
   logic [31:0] s4_byp_val;

   // Operands carry three guard bits below the mantissa; shifted-out bits are truncated.
   always_comb begin
      b_sign = b[31] ^ sub;
      a_big  = a[30:0] >= b[30:0];
      a_m    = {1'b1, a[22:0], 3'b000};
      b_m    = {1'b1, b[22:0], 3'b000};
      diff   = a_big ? (a[30:23] - b[30:23]) : (b[30:23] - a[30:23]);
   end

   // NOTE: every variable written in always_comb is given a default first so no latch is inferred.
   always_comb begin
      lz = '0;
      for (int i = 0; i < 27; i++) begin
         if (s3_m[i]) lz = 5'(26 - i);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) vld <= '0;
      else       vld <= {vld[3:0], start};
   end

   // NOTE: pipeline data registers have no reset; only the valid bits need a defined value.
   always_ff @(posedge clock) begin
      s1_sign    <= a_big ? a[31] : b_sign;
      s1_exp     <= a_big ? a[30:23] : b[30:23];
      s1_big     <= a_big ? a_m : b_m;
      s1_small   <= (a_big ? b_m : a_m) >> diff;
      s1_eff_sub <= a[31] ^ b_sign;
      s1_byp     <= (a[30:23] == 8'd0) || (b[30:23] == 8'd0);
      s1_byp_val <= (a[30:23] == 8'd0) ? {b_sign, b[30:0]} : a;

      s2_sum     <= s1_eff_sub ? ({1'b0, s1_big} - {1'b0, s1_small})
                               : ({1'b0, s1_big} + {1'b0, s1_small});
      s2_sign    <= s1_sign;
      s2_exp     <= s1_exp;
      s2_byp     <= s1_byp;
      s2_byp_val <= s1_byp_val;

      s3_zero    <= (s2_sum == '0);
      s3_m       <= s2_sum[27] ? s2_sum[27:1] : s2_sum[26:0];
      s3_exp     <= s2_sum[27] ? (s2_exp + 8'd1) : s2_exp;
      s3_sign    <= s2_sign;
      s3_byp     <= s2_byp;
      s3_byp_val <= s2_byp_val;

      s4_man     <= 23'((s3_m << lz) >> 3);
      s4_exp     <= s3_exp - {3'b000, lz};
      s4_zero    <= s3_zero;
      s4_sign    <= s3_sign;
      s4_byp     <= s3_byp;
      s4_byp_val <= s3_byp_val;

      result     <= s4_byp ? s4_byp_val : (s4_zero ? 32'd0 : {s4_sign, s4_exp, s4_man});
   end

   assign done = vld[4];
endmodule

module subset_coord_gen #(
   parameter int MAX_SIZE = 41,
   parameter int CNT_W    = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             param_ready,
   input  logic [31:0]      subset_centerpoint_x,
   input  logic [31:0]      subset_centerpoint_y,
   input  logic [CNT_W-1:0] subset_size,
   input  logic [31:0]      half_subset_size,
   input  logic             col_major,
   output logic             coord_valid,
   input  logic             coord_ready,
   output logic [31:0]      coord_x,
   output logic [31:0]      coord_y,
   output logic [CNT_W-1:0] coord_index,
   output logic             coord_last,
   output logic             busy,
   output logic             sub_done,
   output logic             param_err
);
   localparam logic [31:0]      FP_ONE  = 32'h3F80_0000;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] MAX_SZ  = CNT_W'(MAX_SIZE);

   typedef enum logic [2:0] {S_IDLE, S_SUB_X, S_SUB_Y, S_EMIT, S_STEP, S_DONE} state_t;
   state_t state, next;

   logic [31:0]      cx_r, cy_r, half_r, x0_r, y0_r, cur_x, cur_y;
   logic [CNT_W-1:0] size_r, last_idx, index, row, col;
   logic             col_major_r, issued;
   logic             legal, wrap, step_x, is_last;
   logic             fp_start, fp_sub, fp_done;
   logic [31:0]      fp_a, fp_b, fp_res;

   subset_fp32_add u_add (
      .clock  (clock),
      .reset  (reset),
      .start  (fp_start),
      .a      (fp_a),
      .b      (fp_b),
      .sub    (fp_sub),
      .done   (fp_done),
      .result (fp_res)
   );

   assign legal   = (subset_size != '0) && (subset_size <= MAX_SZ);
   assign wrap    = col_major_r ? (row == size_r - CNT_ONE) : (col == size_r - CNT_ONE);
   // The slow axis advances only when the fast axis wraps.
   assign step_x  = col_major_r ? wrap : !wrap;
   assign is_last = (index == last_idx);

   always_comb begin
      next     = state;
      fp_start = 1'b0;
      fp_a     = step_x ? cur_x : cur_y;
      fp_b     = FP_ONE;
      fp_sub   = 1'b0;
      case (state)
         S_IDLE, S_DONE: if (param_ready) next = legal ? S_SUB_X : S_DONE;
         S_SUB_X: begin
            fp_a     = cx_r;
            fp_b     = half_r;
            fp_sub   = 1'b1;
            fp_start = !issued;
            if (fp_done) next = S_SUB_Y;
         end
         S_SUB_Y: begin
            fp_a     = cy_r;
            fp_b     = half_r;
            fp_sub   = 1'b1;
            fp_start = !issued;
            if (fp_done) next = S_EMIT;
         end
         S_EMIT: if (coord_ready) next = is_last ? S_DONE : S_STEP;
         S_STEP: begin
            fp_start = !issued;
            if (fp_done) next = S_EMIT;
         end
         default: next = S_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= S_IDLE;
         cx_r        <= '0;
         cy_r        <= '0;
         half_r      <= '0;
         x0_r        <= '0;
         y0_r        <= '0;
         cur_x       <= '0;
         cur_y       <= '0;
         size_r      <= '0;
         last_idx    <= '0;
         index       <= '0;
         row         <= '0;
         col         <= '0;
         col_major_r <= 1'b0;
         issued      <= 1'b0;
         sub_done    <= 1'b0;
         param_err   <= 1'b0;
      end else begin
         state <= next;
         if (fp_start) issued <= 1'b1;
         if (fp_done)  issued <= 1'b0;
         case (state)
            S_IDLE, S_DONE: if (param_ready) begin
               cx_r        <= subset_centerpoint_x;
               cy_r        <= subset_centerpoint_y;
               half_r      <= half_subset_size;
               size_r      <= subset_size;
               last_idx    <= subset_size * subset_size - CNT_ONE;
               col_major_r <= col_major;
               sub_done    <= !legal;
               param_err   <= !legal;
            end
            S_SUB_X: if (fp_done) begin
               x0_r  <= fp_res;
               cur_x <= fp_res;
            end
            S_SUB_Y: if (fp_done) begin
               y0_r  <= fp_res;
               cur_y <= fp_res;
               index <= '0;
               row   <= '0;
               col   <= '0;
            end
            S_EMIT: if (coord_ready && is_last) sub_done <= 1'b1;
            S_STEP: if (fp_done) begin
               index <= index + CNT_ONE;
               if (step_x) cur_x <= fp_res;
               else        cur_y <= fp_res;
               if (col_major_r) begin
                  if (wrap) begin
                     cur_y <= y0_r;
                     row   <= '0;
                     col   <= col + CNT_ONE;
                  end else begin
                     row <= row + CNT_ONE;
                  end
               end else begin
                  if (wrap) begin
                     cur_x <= x0_r;
                     col   <= '0;
                     row   <= row + CNT_ONE;
                  end else begin
                     col <= col + CNT_ONE;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign coord_valid = (state == S_EMIT);
   assign coord_x     = cur_x;
   assign coord_y     = cur_y;
   assign coord_index = index;
   assign coord_last  = coord_valid && is_last;
   assign busy        = (state == S_SUB_X) || (state == S_SUB_Y) ||
                        (state == S_EMIT)  || (state == S_STEP);
endmodule
